hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the ID-stage hazard detector.
- Replaces fixed load-use and custom-op pattern matching with a per-register busy/countdown scoreboard.
- Tracks arbitrary result latencies (load, mul/div, accelerator) plus an in-flight counter for accelerator ops. Store-class accelerator ops are held until all outstanding accelerator work drains.
- Sits beside the decoder and drives the IF/ID stall and the branch flush.

Parameters:
- NUM_REGS, 32, architectural registers tracked; x0 is never busy.
- REG_AW, 5, register index width; must satisfy 2**REG_AW >= NUM_REGS.
- LAT_W, 4, latency field width; max latency 2**LAT_W-1.
- MAX_INFLIGHT, 4, max outstanding accelerator ops; must be >= 1.
- CNT_W, 3, in-flight counter width; must hold MAX_INFLIGHT.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decoded instruction present in ID.
- id_rs1  in  REG_AW  source 1 index.
- id_rs2  in  REG_AW  source 2 index.
- id_rs1_used  in  1  rs1 is read.
- id_rs2_used  in  1  rs2 is read.
- id_rd  in  REG_AW  destination index.
- id_rd_wr  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles until the result is forwardable; 0 = bypass-ready next cycle.
- id_is_acc  in  1  accelerator op (PA class).
- id_is_acc_sync  in  1  op that must wait for accelerator drain (store / M2 class).
- acc_done  in  1  one-cycle pulse: one accelerator op retired.
- br_ctrl  in  1  branch taken / redirect.
- issue_stall  out  1  hold PC and IF/ID; insert bubble into EX.
- flush  out  1  kill IF/ID.
- busy_vec  out  NUM_REGS  current busy bits (debug).
- acc_inflight  out  CNT_W  outstanding accelerator ops.
- raw_stall_cnt  out  32  see Optional Feature.
- acc_stall_cnt  out  32  see Optional Feature.

Behaviour:
- Reset values: busy_vec=0, all countdowns=0, acc_inflight=0, counters=0. The stall/flush outputs are combinational and therefore 0 after reset with idle inputs.
- flush = br_ctrl, same cycle, combinational.
- raw_hz = (id_rs1_used & id_rs1!=0 & busy[id_rs1]) | (id_rs2_used & id_rs2!=0 & busy[id_rs2]).
- waw_hz = id_rd_wr & id_rd!=0 & busy[id_rd].
- acc_hz = (id_is_acc & acc_inflight==MAX_INFLIGHT) | (id_is_acc_sync & acc_inflight!=0).
- issue_stall = id_valid & ~br_ctrl & (raw_hz | waw_hz | acc_hz). Flush has priority: stall is 0 when br_ctrl=1.
- issue = id_valid & ~br_ctrl & ~issue_stall.
- Countdown, each cycle, for each busy register: cnt decrements; when cnt==1 at the edge, busy clears and cnt goes to 0.
- Issue with id_rd_wr, id_rd!=0, id_lat>0: busy[id_rd]<=1, cnt[id_rd]<=id_lat. No clash with countdown is possible, because waw_hz blocks issue to a busy rd.
- Timing: producer issued in cycle t with lat L leaves rd busy in cycles t+1..t+L. The earliest dependent issue is cycle t+L+1. Lat 1 (load) therefore gives the classic single bubble.
- Issue with id_lat==0 sets no state.
- acc_inflight: +1 on issue of id_is_acc; -1 on acc_done; both in the same cycle = unchanged.
- acc_done while acc_inflight==0: ignored, counter stays 0.
- Increment beyond MAX_INFLIGHT cannot occur because acc_hz blocks it.
- br_ctrl does not clear scoreboard entries or in-flight count; those belong to older, already-issued ops.
- rst asserted mid-countdown: all state cleared at that edge, any pending stall drops the next cycle.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- Defined: raw_stall_cnt increments each cycle with issue_stall & (raw_hz|waw_hz). acc_stall_cnt increments each cycle with issue_stall & acc_hz & ~(raw_hz|waw_hz). Both are 32-bit, saturate at 0xFFFFFFFF, and clear on rst.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: issue rd=5, lat=1, cycle t; cycle t+1 rs1=5 used -> issue_stall=1 one cycle; cycle t+2 -> issue_stall=0, busy_vec[5]=0.
- Long latency: issue rd=7, lat=4; dependent on rs2=7 presented every cycle -> stall exactly 4 cycles, issues at t+5. Same sequence with rd=0 -> never stalls.
- WAW: rd=9 busy (lat 3); next op writes rd=9 with lat 1, no sources -> stalled until busy_vec[9]=0.
- Accelerator cap, MAX_INFLIGHT=4: issue 4 acc ops -> acc_inflight=4; 5th stalled; acc_done pulse -> 5th issues next cycle, inflight stays 4. Acc issue and acc_done in the same cycle -> unchanged.
- Sync drain: acc_inflight=2; acc_sync op stalls until two acc_done pulses (inflight=0), then issues. acc_done at inflight=0 -> stays 0.
- Flush/reset: raw hazard present with br_ctrl=1 -> flush=1, issue_stall=0, busy unchanged. rst mid-countdown -> busy_vec=0 next cycle. With HAZ_PERF_CNT_EN, the 4-cycle stall gives raw_stall_cnt=4.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage per-register busy/countdown scoreboard plus
// accelerator in-flight tracking; drives the IF/ID stall and branch flush.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   id_*              decoded instruction fields presented in ID
//   acc_done          one-cycle pulse, one accelerator op retired
//   br_ctrl           branch taken / redirect
//   issue_stall       hold PC and IF/ID, bubble into EX
//   flush             kill IF/ID (equals br_ctrl)
//   busy_vec          per-register busy bits (debug)
//   acc_inflight      outstanding accelerator ops
//   raw_stall_cnt     register-hazard stall cycles (perf)
//   acc_stall_cnt     accelerator-only stall cycles (perf)
//
// Optional: define HAZ_PERF_CNT_EN to build the two saturating stall counters;
// otherwise both perf outputs are tied to zero and no counter flops exist.

module hazard_scoreboard #(
    parameter int NUM_REGS     = 32,
    parameter int REG_AW       = 5,
    parameter int LAT_W        = 4,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                id_valid,
    input  logic [REG_AW-1:0]   id_rs1,
    input  logic [REG_AW-1:0]   id_rs2,
    input  logic                id_rs1_used,
    input  logic                id_rs2_used,
    input  logic [REG_AW-1:0]   id_rd,
    input  logic                id_rd_wr,
    input  logic [LAT_W-1:0]    id_lat,
    input  logic                id_is_acc,
    input  logic                id_is_acc_sync,
    input  logic                acc_done,
    input  logic                br_ctrl,
    output logic                issue_stall,
    output logic                flush,
    output logic [NUM_REGS-1:0] busy_vec,
    output logic [CNT_W-1:0]    acc_inflight,
    output logic [31:0]         raw_stall_cnt,
    output logic [31:0]         acc_stall_cnt
);

    logic [NUM_REGS-1:0] busy;
    logic [LAT_W-1:0]    cnt [NUM_REGS];
    logic [CNT_W-1:0]    inflight;

    logic rs1_busy;
    logic rs2_busy;
    logic rd_busy;
    logic raw_hz;
    logic waw_hz;
    logic acc_hz;
    logic issue;
    logic acc_inc;
    logic acc_dec;

    // Lookup loops start at 1 so x0 can never report busy, and indices
    // beyond NUM_REGS simply match nothing.
    always_comb begin
        rs1_busy = 1'b0;
        rs2_busy = 1'b0;
        rd_busy  = 1'b0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (id_rs1 == REG_AW'(i)) rs1_busy = busy[i];
            if (id_rs2 == REG_AW'(i)) rs2_busy = busy[i];
            if (id_rd  == REG_AW'(i)) rd_busy  = busy[i];
        end
    end

    assign raw_hz = (id_rs1_used & rs1_busy) | (id_rs2_used & rs2_busy);
    assign waw_hz = id_rd_wr & rd_busy;
    assign acc_hz = (id_is_acc & (inflight == CNT_W'(MAX_INFLIGHT)))
                  | (id_is_acc_sync & (inflight != '0));

    // Redirect wins: a squashed instruction must never hold the front end.
    assign issue_stall = id_valid & ~br_ctrl & (raw_hz | waw_hz | acc_hz);
    assign issue       = id_valid & ~br_ctrl & ~issue_stall;
    assign flush       = br_ctrl;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (busy[i]) begin
                    if (cnt[i] == LAT_W'(1)) begin
                        busy[i] <= 1'b0;
                        cnt[i]  <= '0;
                    end else begin
                        cnt[i] <= cnt[i] - LAT_W'(1);
                    end
                end
                // waw_hz keeps a new producer away from a busy rd,
                // so this never overlaps the countdown above.
                if (issue && id_rd_wr && (i != 0) &&
                    (id_rd == REG_AW'(i)) && (id_lat != '0)) begin
                    busy[i] <= 1'b1;
                    cnt[i]  <= id_lat;
                end
            end
        end
    end

    assign acc_inc = issue & id_is_acc;
    // A stray retire pulse with nothing outstanding is dropped.
    assign acc_dec = acc_done & (inflight != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({acc_inc, acc_dec})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    assign busy_vec     = busy;
    assign acc_inflight = inflight;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] raw_cnt_q;
    logic [31:0] acc_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_cnt_q <= '0;
            acc_cnt_q <= '0;
        end else begin
            if (issue_stall && (raw_hz || waw_hz) && (raw_cnt_q != '1)) begin
                raw_cnt_q <= raw_cnt_q + 32'd1;
            end
            if (issue_stall && acc_hz && !(raw_hz || waw_hz) &&
                (acc_cnt_q != '1)) begin
                acc_cnt_q <= acc_cnt_q + 32'd1;
            end
        end
    end

    assign raw_stall_cnt = raw_cnt_q;
    assign acc_stall_cnt = acc_cnt_q;
`else
    assign raw_stall_cnt = '0;
    assign acc_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed bench for hazard_scoreboard.
// One task per scenario, each with its own inline comparisons.

module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  id_rd;
    logic        id_rd_wr;
    logic [3:0]  id_lat;
    logic        id_is_acc;
    logic        id_is_acc_sync;
    logic        acc_done;
    logic        br_ctrl;
    logic        issue_stall;
    logic        flush;
    logic [31:0] busy_vec;
    logic [2:0]  acc_inflight;
    logic [31:0] raw_stall_cnt;
    logic [31:0] acc_stall_cnt;

    int checks;
    int failures;

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_rs1_used    (id_rs1_used),
        .id_rs2_used    (id_rs2_used),
        .id_rd          (id_rd),
        .id_rd_wr       (id_rd_wr),
        .id_lat         (id_lat),
        .id_is_acc      (id_is_acc),
        .id_is_acc_sync (id_is_acc_sync),
        .acc_done       (acc_done),
        .br_ctrl        (br_ctrl),
        .issue_stall    (issue_stall),
        .flush          (flush),
        .busy_vec       (busy_vec),
        .acc_inflight   (acc_inflight),
        .raw_stall_cnt  (raw_stall_cnt),
        .acc_stall_cnt  (acc_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, got timeout, want done");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid       = 1'b0;
        id_rs1         = '0;
        id_rs2         = '0;
        id_rs1_used    = 1'b0;
        id_rs2_used    = 1'b0;
        id_rd          = '0;
        id_rd_wr       = 1'b0;
        id_lat         = '0;
        id_is_acc      = 1'b0;
        id_is_acc_sync = 1'b0;
        acc_done       = 1'b0;
        br_ctrl        = 1'b0;
    endtask

    task automatic drive(input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2,
                         input logic [4:0] rd, input logic wr,
                         input logic [3:0] lat,
                         input logic acc, input logic sync);
        id_valid       = 1'b1;
        id_rs1         = rs1;
        id_rs1_used    = u1;
        id_rs2         = rs2;
        id_rs2_used    = u2;
        id_rd          = rd;
        id_rd_wr       = wr;
        id_lat         = lat;
        id_is_acc      = acc;
        id_is_acc_sync = sync;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL reset_busy got=%h want=0", busy_vec);
        end
        checks++;
        if (acc_inflight !== 3'd0) begin
            failures++;
            $display("FAIL reset_inflight got=%0d want=0", acc_inflight);
        end
        checks++;
        if (issue_stall !== 1'b0 || flush !== 1'b0) begin
            failures++;
            $display("FAIL reset_outs got=%b%b want=00", issue_stall, flush);
        end
        checks++;
        if (raw_stall_cnt !== 32'd0 || acc_stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL reset_perf got=%0d/%0d want=0/0",
                     raw_stall_cnt, acc_stall_cnt);
        end
        cyc();
    endtask

    task automatic test_load_use();
        do_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd1, 1'b0, 1'b0);
        #1;
        checks++;
        if (issue_stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_producer got=%b want=0", issue_stall);
        end
        cyc();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 4'd0, 1'b0, 1'b0);
        #1;
        checks++;
        if (issue_stall !== 1'b1 || busy_vec !== 32'h20) begin
            failures++;
            $display("FAIL lu_bubble got=%b/%h want=1/00000020",
                     issue_stall, busy_vec);
        end
        cyc();
        #1;
        checks++;
        if (issue_stall !== 1'b0 || busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL lu_release got=%b/%h want=0/00000000",
                     issue_stall, busy_vec);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL lu_lat0 got=%h want=0", busy_vec);
        end
        cyc();
    endtask

    task automatic test_long_latency();
        logic exp;
        do_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 4'd4, 1'b0, 1'b0);
        cyc();
        for (int k = 1; k <= 5; k++) begin
            drive(5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
            #1;
            exp = (k <= 4);
            checks++;
            if (issue_stall !== exp) begin
                failures++;
                $display("FAIL long_stall k=%0d got=%b want=%b",
                         k, issue_stall, exp);
            end
            if (k == 5) begin
                checks++;
`ifdef HAZ_PERF_CNT_EN
                if (raw_stall_cnt !== 32'd4) begin
                    failures++;
                    $display("FAIL perf_raw got=%0d want=4", raw_stall_cnt);
                end
`else
                if (raw_stall_cnt !== 32'd0) begin
                    failures++;
                    $display("FAIL perf_raw_off got=%0d want=0",
                             raw_stall_cnt);
                end
`endif
            end
            cyc();
        end
        idle();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 4'd4, 1'b0, 1'b0);
        cyc();
        for (int k = 1; k <= 5; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
            #1;
            checks++;
            if (issue_stall !== 1'b0 || busy_vec !== 32'h0) begin
                failures++;
                $display("FAIL x0_stall k=%0d got=%b/%h want=0/0",
                         k, issue_stall, busy_vec);
            end
            cyc();
        end
        idle();
    endtask

    task automatic test_waw();
        logic exp;
        do_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd3, 1'b0, 1'b0);
        cyc();
        for (int k = 1; k <= 4; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 4'd1, 1'b0, 1'b0);
            #1;
            exp = (k <= 3);
            checks++;
            if (issue_stall !== exp || busy_vec[9] !== exp) begin
                failures++;
                $display("FAIL waw k=%0d got=%b/%b want=%b/%b",
                         k, issue_stall, busy_vec[9], exp, exp);
            end
            cyc();
        end
        idle();
        #1;
        checks++;
        if (busy_vec !== 32'h200) begin
            failures++;
            $display("FAIL waw_set got=%h want=00000200", busy_vec);
        end
        cyc();
        #1;
        checks++;
        if (busy_vec !== 32'h0) begin
            failures++;
            $display("FAIL waw_clear got=%h want=0", busy_vec);
        end
        cyc();
    endtask

    task automatic test_acc_cap();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
            #1;
            checks++;
            if (issue_stall !== 1'b0) begin
                failures++;
                $display("FAIL acc_fill k=%0d got=%b want=0", k, issue_stall);
            end
            cyc();
        end
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        #1;
        checks++;
        if (acc_inflight !== 3'd4 || issue_stall !== 1'b1) begin
            failures++;
            $display("FAIL acc_full got=%0d/%b want=4/1",
                     acc_inflight, issue_stall);
        end
        cyc();
        acc_done = 1'b1;
        #1;
        checks++;
        if (issue_stall !== 1'b1) begin
            failures++;
            $display("FAIL acc_hold got=%b want=1", issue_stall);
        end
        cyc();
        acc_done = 1'b0;
        #1;
        checks++;
        if (issue_stall !== 1'b0 || acc_inflight !== 3'd3) begin
            failures++;
            $display("FAIL acc_fifth got=%b/%0d want=0/3",
                     issue_stall, acc_inflight);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (acc_inflight !== 3'd4) begin
            failures++;
            $display("FAIL acc_refill got=%0d want=4", acc_inflight);
        end
        acc_done = 1'b1;
        cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        acc_done = 1'b1;
        #1;
        checks++;
        if (issue_stall !== 1'b0 || acc_inflight !== 3'd3) begin
            failures++;
            $display("FAIL acc_both_pre got=%b/%0d want=0/3",
                     issue_stall, acc_inflight);
        end
        cyc();
        idle();
        #1;
        checks++;
        if (acc_inflight !== 3'd3) begin
            failures++;
            $display("FAIL acc_both got=%0d want=3", acc_inflight);
        end
        cyc();
    endtask

    task automatic test_sync_drain();
        do_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b1, 1'b0);
        cyc();
        cyc();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b1);
        #1;
        checks++;
        if (acc_inflight !== 3'd2 || issue_stall !== 1'b1) begin
            failures++;
            $display("FAIL sync_wait2 got=%0d/%b want=2/1",
                     acc_inflight, issue_stall);
        end
        acc_done = 1'b1;
        cyc();
        #1;
        checks++;
        if (acc_inflight !== 3'd1 || issue_stall !== 1'b1) begin
            failures++;
            $display("FAIL sync_wait1 got=%0d/%b want=1/1",
                     acc_inflight, issue_stall);
        end
        cyc();
        acc_done = 1'b0;
        #1;
        checks++;
        if (acc_inflight !== 3'd0 || issue_stall !== 1'b0) begin
            failures++;
            $display("FAIL sync_go got=%0d/%b want=0/0",
                     acc_inflight, issue_stall);
        end
        cyc();
        idle();
        acc_done = 1'b1;
        cyc();
        acc_done = 1'b0;
        #1;
        checks++;
        if (acc_inflight !== 3'd0) begin
            failures++;
            $display("FAIL sync_stray got=%0d want=0", acc_inflight);
        end
        cyc();
    endtask

    task automatic test_flush_reset();
        do_reset();
        drive(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 4'd3, 1'b0, 1'b0);
        cyc();
        drive(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        br_ctrl = 1'b1;
        #1;
        checks++;
        if (flush !== 1'b1 || issue_stall !== 1'b0 || busy_vec !== 32'h20) begin
            failures++;
            $display("FAIL flush got=%b/%b/%h want=1/0/00000020",
                     flush, issue_stall, busy_vec);
        end
        cyc();
        br_ctrl = 1'b0;
        #1;
        checks++;
        if (flush !== 1'b0 || issue_stall !== 1'b1 || busy_vec !== 32'h20) begin
            failures++;
            $display("FAIL post_flush got=%b/%b/%h want=0/1/00000020",
                     flush, issue_stall, busy_vec);
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        checks++;
        if (busy_vec !== 32'h0 || issue_stall !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset got=%h/%b want=0/0",
                     busy_vec, issue_stall);
        end
        cyc();
        idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        idle();
        test_reset();
        test_load_use();
        test_long_latency();
        test_waw();
        test_acc_cap();
        test_sync_drain();
        test_flush_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
